// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver: synchronizes rxd, oversamples each bit mid-point and
// hands completed bytes to the consumer through a one-entry valid/ready register.
module uart_byte_receiver #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115_200,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CNT_W = $clog2(OVERSAMPLE);

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);

   if (DIV < 1) begin : g_div_check
      $error("uart_byte_receiver: CLK_FREQ/(BAUD*OVERSAMPLE) must be at least 1");
   end

   if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_os_check
      $error("uart_byte_receiver: OVERSAMPLE must be even and at least 4");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   state_t           state;
   logic             rxd_meta;
   logic             rx_s;
   logic [DIV_W-1:0] div_cnt;
   logic [CNT_W-1:0] tick_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;
   logic             tick;

   assign tick = (div_cnt == DIV_LAST);
   assign busy = (state != S_IDLE);

   // Synchronizer, baud tick divider, frame FSM and the holding register share
   // one clocked process so delivery and consumer hand-off resolve in one place.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         rxd_meta  <= 1'b1;
         rx_s      <= 1'b1;
         div_cnt   <= '0;
         tick_cnt  <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         rxd_meta  <= rxd;
         rx_s      <= rxd_meta;
         div_cnt   <= tick ? '0 : div_cnt + 1'b1;

         // A delivery later in this block overrides this clear.
         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               if (!rx_s) begin
                  state    <= S_START;
                  tick_cnt <= '0;
                  div_cnt  <= '0;
               end
            end

            S_START: begin
               if (tick) begin
                  if (tick_cnt == HALF_LAST) begin
                     tick_cnt <= '0;
                     bit_idx  <= '0;
                     state    <= rx_s ? S_IDLE : S_DATA;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end

            S_DATA: begin
               if (tick) begin
                  if (tick_cnt == FULL_LAST) begin
                     tick_cnt       <= '0;
                     shift[bit_idx] <= rx_s;
                     bit_idx        <= bit_idx + 1'b1;
                     if (bit_idx == 3'd7) begin
                        state <= S_STOP;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end

            // Line held low through the stop slot is a framing error; the
            // byte is dropped and we wait for the line to return high.
            S_STOP: begin
               if (tick) begin
                  if (tick_cnt == FULL_LAST) begin
                     tick_cnt <= '0;
                     if (rx_s) begin
                        state <= S_IDLE;
                        if (!rx_valid || rx_ready) begin
                           rx_data  <= shift;
                           rx_valid <= 1'b1;
                        end else begin
                           overrun <= 1'b1;
                        end
                     end else begin
                        frame_err <= 1'b1;
                        state     <= S_WAIT_IDLE;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end

            S_WAIT_IDLE: begin
               if (rx_s) begin
                  state <= S_IDLE;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Directed bench for uart_byte_receiver at the fast rate (DIV=2, 32 clk/bit),
// driving cycle-exact 8N1 frames and checking outputs with immediate assertions.
module tb_uart_byte_receiver;

   localparam int BIT_CLKS   = 32;
   localparam int FRAME_CLKS = 10 * BIT_CLKS;

   logic       clk = 1'b0;
   logic       rst;
   logic       rxd;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int         errors = 0;
   int         checks = 0;
   int         fe_cnt = 0;
   int         ov_cnt = 0;
   int         both_cnt = 0;
   logic [7:0] got_q[$];

   uart_byte_receiver #(
      .CLK_FREQ  (50_000_000),
      .BAUD      (1_562_500),
      .OVERSAMPLE(16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rxd      (rxd),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .frame_err(frame_err),
      .overrun  (overrun),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Record every consumer transfer and every flag pulse between clock edges.
   always @(negedge clk) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_err && overrun) both_cnt++;
   end

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [7:0] last_got();
      if (got_q.size() == 0) return 8'h00;
      return got_q[got_q.size() - 1];
   endfunction

   // One frame, one clock per iteration; ready_at/rst_at (>=0) pick the
   // frame-relative cycle at which rx_ready rises or a 1-cycle reset is applied.
   task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                                input int ready_at, input int rst_at);
      logic [9:0] frame;
      frame = {stop_bit, data, 1'b0};
      for (int c = 0; c < FRAME_CLKS; c++) begin
         rxd = frame[c / BIT_CLKS];
         if (c == ready_at) rx_ready = 1'b1;
         if (rst_at >= 0 && c == rst_at) rst = 1'b1;
         if (rst_at >= 0 && c == rst_at + 1) begin
            rst = 1'b0;
            checkOutput("mid_rst_valid", 32'(rx_valid), 32'd0);
            checkOutput("mid_rst_data", 32'(rx_data), 32'h00);
            checkOutput("mid_rst_busy", 32'(busy), 32'd0);
         end
         wait_cycles(1);
      end
   endtask

   initial begin
      rst      = 1'b1;
      rxd      = 1'b1;
      rx_ready = 1'b0;
      wait_cycles(3);
      checkOutput("reset_data", 32'(rx_data), 32'h00);
      checkOutput("reset_valid", 32'(rx_valid), 32'd0);
      checkOutput("reset_ferr", 32'(frame_err), 32'd0);
      checkOutput("reset_ovr", 32'(overrun), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      wait_cycles(5);

      $display("[TB] clean byte 0x44");
      rx_ready = 1'b1;
      applyStimulus(8'h44, 1'b1, -1, -1);
      wait_cycles(4);
      checkOutput("t1_count", 32'(got_q.size()), 32'd1);
      checkOutput("t1_byte", 32'(last_got()), 32'h44);
      checkOutput("t1_busy", 32'(busy), 32'd0);
      checkOutput("t1_flags", 32'(fe_cnt + ov_cnt), 32'd0);

      $display("[TB] start glitch");
      rxd = 1'b0;
      wait_cycles(5);
      rxd = 1'b1;
      checkOutput("t2_busy_start", 32'(busy), 32'd1);
      wait_cycles(40);
      checkOutput("t2_busy_end", 32'(busy), 32'd0);
      checkOutput("t2_count", 32'(got_q.size()), 32'd1);
      checkOutput("t2_ferr", 32'(fe_cnt), 32'd0);

      $display("[TB] framing error then 0x3C");
      applyStimulus(8'hA5, 1'b0, -1, -1);
      wait_cycles(3 * BIT_CLKS);
      checkOutput("t3_ferr", 32'(fe_cnt), 32'd1);
      checkOutput("t3_busy_low", 32'(busy), 32'd1);
      checkOutput("t3_valid", 32'(rx_valid), 32'd0);
      rxd = 1'b1;
      wait_cycles(20);
      checkOutput("t3_busy_idle", 32'(busy), 32'd0);
      applyStimulus(8'h3C, 1'b1, -1, -1);
      wait_cycles(4);
      checkOutput("t3_count", 32'(got_q.size()), 32'd2);
      checkOutput("t3_byte", 32'(last_got()), 32'h3C);

      $display("[TB] overrun");
      rx_ready = 1'b0;
      applyStimulus(8'h11, 1'b1, -1, -1);
      checkOutput("t4_valid", 32'(rx_valid), 32'd1);
      checkOutput("t4_data", 32'(rx_data), 32'h11);
      applyStimulus(8'h22, 1'b1, -1, -1);
      checkOutput("t4_ovr", 32'(ov_cnt), 32'd1);
      checkOutput("t4_data_kept", 32'(rx_data), 32'h11);
      rx_ready = 1'b1;
      wait_cycles(1);
      checkOutput("t4_valid_drop", 32'(rx_valid), 32'd0);
      checkOutput("t4_count", 32'(got_q.size()), 32'd3);
      checkOutput("t4_byte", 32'(last_got()), 32'h11);
      wait_cycles(16);

      $display("[TB] accept in stop-sample cycle");
      rx_ready = 1'b0;
      applyStimulus(8'h11, 1'b1, -1, -1);
      applyStimulus(8'h22, 1'b1, 306, -1);
      wait_cycles(4);
      checkOutput("t5_ovr", 32'(ov_cnt), 32'd1);
      checkOutput("t5_count", 32'(got_q.size()), 32'd5);
      checkOutput("t5_first", 32'(got_q[3]), 32'h11);
      checkOutput("t5_second", 32'(got_q[4]), 32'h22);
      checkOutput("t5_valid", 32'(rx_valid), 32'd0);

      $display("[TB] reset mid-frame");
      rx_ready = 1'b0;
      applyStimulus(8'h77, 1'b1, -1, -1);
      checkOutput("t6_pre_data", 32'(rx_data), 32'h77);
      applyStimulus(8'h5A, 1'b1, -1, 176);
      // Falling edge into bit 5 starts a fresh frame: 0,1,0,stop=1,idle -> 0xFD
      wait_cycles(250);
      checkOutput("t6_phantom_valid", 32'(rx_valid), 32'd1);
      checkOutput("t6_phantom_data", 32'(rx_data), 32'hFD);
      rx_ready = 1'b1;
      wait_cycles(2);
      checkOutput("t6_count_a", 32'(got_q.size()), 32'd6);
      applyStimulus(8'h5A, 1'b1, -1, -1);
      wait_cycles(4);
      checkOutput("t6_count_b", 32'(got_q.size()), 32'd7);
      checkOutput("t6_byte", 32'(last_got()), 32'h5A);

      checkOutput("final_ferr", 32'(fe_cnt), 32'd1);
      checkOutput("final_ovr", 32'(ov_cnt), 32'd1);
      checkOutput("final_both", 32'(both_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
